// File: rtl/exe_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage and the branch unit:
// ARM condition-code encodings, NZCV bit positions and the default datapath width.
package exe_mem_stage_pkg;

  localparam int DATA_W_DEF = 32;

  // Bit positions inside a 4-bit {N,Z,C,V} status word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition field encoding. NV is reserved and never executes.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Control half of the EX/MEM pipeline register.
  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic [3:0] dest;
  } mem_ctrl_t;

endpackage

// File: rtl/exe_mem_stage_if.sv
// Bus between the EX side (ALU, hazard unit, decode) and the EX/MEM stage.
interface exe_mem_stage_if
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              freeze;
  logic              flush;
  logic              ex_valid;
  logic              ex_s;
  logic [3:0]        ex_status;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [3:0]        ex_dest;
  logic              ex_wb_en;
  logic              ex_mem_r;
  logic              ex_mem_w;
  logic [3:0]        id_cond;

  logic [3:0]        sr;
  logic              id_cond_ok;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [3:0]        mem_dest;
  logic              mem_wb_en;
  logic              mem_mem_r;
  logic              mem_mem_w;

  modport master (
    output freeze, flush, ex_valid, ex_s, ex_status, ex_result, ex_store_data,
           ex_dest, ex_wb_en, ex_mem_r, ex_mem_w, id_cond,
    input  sr, id_cond_ok, mem_valid, mem_result, mem_store_data, mem_dest,
           mem_wb_en, mem_mem_r, mem_mem_w
  );

  modport slave (
    input  freeze, flush, ex_valid, ex_s, ex_status, ex_result, ex_store_data,
           ex_dest, ex_wb_en, ex_mem_r, ex_mem_w, id_cond,
    output sr, id_cond_ok, mem_valid, mem_result, mem_store_data, mem_dest,
           mem_wb_en, mem_mem_r, mem_mem_w
  );

endinterface

// File: rtl/exe_mem_stage_cond_check.sv
// Combinational ARM condition evaluator: does a 4-bit condition pass
// against a {N,Z,C,V} flag word. Shared with the branch unit.
module cond_check
  import exe_mem_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field against the flags.
  always_comb begin
    // NOTE: default first so every path assigns pass and no latch is inferred.
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EX/MEM stage: latches ALU result and controls into the EX/MEM register,
// owns the architectural NZCV register and evaluates the ID condition field.
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter bit COND_BYPASS = 1'b1
)
(
  input  logic           clk,
  input  logic           rst,
  exe_mem_stage_if.slave bus
);

  logic [3:0]        sr_q;
  logic [3:0]        sr_next;
  logic              sr_update;
  logic [3:0]        cond_flags;
  mem_ctrl_t         ctrl_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] store_data_q;

  // Flags change only for a live, S-bit instruction that is neither stalled nor killed.
  assign sr_update = bus.ex_valid && bus.ex_s && !bus.freeze && !bus.flush;
  assign sr_next   = sr_update ? bus.ex_status : sr_q;

  // Architectural status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      sr_q <= '0;
    end else begin
      sr_q <= sr_next;
    end
  end

  // EX/MEM pipeline register: freeze holds, flush inserts an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data fields are reset too, so MEM never sees X out of reset.
      ctrl_q       <= '0;
      result_q     <= '0;
      store_data_q <= '0;
    end else if (bus.freeze) begin
      ctrl_q       <= ctrl_q;
      result_q     <= result_q;
      store_data_q <= store_data_q;
    end else if (bus.flush) begin
      ctrl_q       <= '0;
      result_q     <= '0;
      store_data_q <= '0;
    end else begin
      ctrl_q.valid <= bus.ex_valid;
      ctrl_q.wb_en <= bus.ex_valid && bus.ex_wb_en;
      ctrl_q.mem_r <= bus.ex_valid && bus.ex_mem_r;
      ctrl_q.mem_w <= bus.ex_valid && bus.ex_mem_w;
      ctrl_q.dest  <= bus.ex_dest;
      result_q     <= bus.ex_result;
      store_data_q <= bus.ex_store_data;
    end
  end

  // The bypass lets an instruction in ID see flags its predecessor writes this cycle.
  assign cond_flags = COND_BYPASS ? sr_next : sr_q;

  cond_check u_cond_check (
    .cond  (bus.id_cond),
    .flags (cond_flags),
    .pass  (bus.id_cond_ok)
  );

  assign bus.sr             = sr_q;
  assign bus.mem_valid      = ctrl_q.valid;
  assign bus.mem_wb_en      = ctrl_q.wb_en;
  assign bus.mem_mem_r      = ctrl_q.mem_r;
  assign bus.mem_mem_w      = ctrl_q.mem_w;
  assign bus.mem_dest       = ctrl_q.dest;
  assign bus.mem_result     = result_q;
  assign bus.mem_store_data = store_data_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: one instance per COND_BYPASS setting,
// both driven identically and compared against a behavioural model.
module tb_exe_mem_stage;

  localparam int DW = 32;

  typedef struct {
    logic          freeze;
    logic          flush;
    logic          valid;
    logic          s;
    logic [3:0]    status;
    logic [DW-1:0] result;
    logic [DW-1:0] sd;
    logic [3:0]    dest;
    logic          wb;
    logic          mr;
    logic          mw;
    logic [3:0]    cond;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t stim;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [3:0]    sr_m;
  logic          mv_m, wb_m, mr_m, mw_m;
  logic [DW-1:0] res_m, sd_m;
  logic [3:0]    dest_m;

  exe_mem_stage_if #(.DATA_W(DW)) if_b ();
  exe_mem_stage_if #(.DATA_W(DW)) if_r ();

  exe_mem_stage #(.DATA_W(DW), .COND_BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  exe_mem_stage #(.DATA_W(DW), .COND_BYPASS(1'b0)) dut_r (.clk(clk), .rst(rst), .bus(if_r));

  assign if_b.freeze = stim.freeze;        assign if_r.freeze = stim.freeze;
  assign if_b.flush = stim.flush;          assign if_r.flush = stim.flush;
  assign if_b.ex_valid = stim.valid;       assign if_r.ex_valid = stim.valid;
  assign if_b.ex_s = stim.s;               assign if_r.ex_s = stim.s;
  assign if_b.ex_status = stim.status;     assign if_r.ex_status = stim.status;
  assign if_b.ex_result = stim.result;     assign if_r.ex_result = stim.result;
  assign if_b.ex_store_data = stim.sd;     assign if_r.ex_store_data = stim.sd;
  assign if_b.ex_dest = stim.dest;         assign if_r.ex_dest = stim.dest;
  assign if_b.ex_wb_en = stim.wb;          assign if_r.ex_wb_en = stim.wb;
  assign if_b.ex_mem_r = stim.mr;          assign if_r.ex_mem_r = stim.mr;
  assign if_b.ex_mem_w = stim.mw;          assign if_r.ex_mem_w = stim.mw;
  assign if_b.id_cond = stim.cond;         assign if_r.id_cond = stim.cond;

  always #5 clk = ~clk;

  // ARM conditions come in pairs: odd codes are the negation of the even one below.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sr_m = '0; mv_m = 0; wb_m = 0; mr_m = 0; mw_m = 0;
    res_m = '0; sd_m = '0; dest_m = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " b.sr"},        if_b.sr,             sr_m);
    check({tag, " b.valid"},     if_b.mem_valid,      mv_m);
    check({tag, " b.result"},    if_b.mem_result,     res_m);
    check({tag, " b.store"},     if_b.mem_store_data, sd_m);
    check({tag, " b.dest"},      if_b.mem_dest,       dest_m);
    check({tag, " b.wb_en"},     if_b.mem_wb_en,      wb_m);
    check({tag, " b.mem_r"},     if_b.mem_mem_r,      mr_m);
    check({tag, " b.mem_w"},     if_b.mem_mem_w,      mw_m);
    check({tag, " r.sr"},        if_r.sr,             sr_m);
    check({tag, " r.valid"},     if_r.mem_valid,      mv_m);
    check({tag, " r.result"},    if_r.mem_result,     res_m);
    check({tag, " r.store"},     if_r.mem_store_data, sd_m);
    check({tag, " r.dest"},      if_r.mem_dest,       dest_m);
    check({tag, " r.wb_en"},     if_r.mem_wb_en,      wb_m);
    check({tag, " r.mem_r"},     if_r.mem_mem_r,      mr_m);
    check({tag, " r.mem_w"},     if_r.mem_mem_w,      mw_m);
  endtask

  // Combinational condition check on the inputs currently driven.
  task automatic check_cond(input string tag);
    logic upd;
    #1;
    upd = stim.valid && stim.s && !stim.freeze && !stim.flush;
    check({tag, " b.cond_ok"}, if_b.id_cond_ok, cond_ref(stim.cond, upd ? stim.status : sr_m));
    check({tag, " r.cond_ok"}, if_r.id_cond_ok, cond_ref(stim.cond, sr_m));
  endtask

  // Advance one clock: model consumes the pre-edge inputs, outputs checked 1 after the edge.
  task automatic step(input string tag);
    logic [3:0] sr_n;
    sr_n = (stim.valid && stim.s && !stim.freeze && !stim.flush) ? stim.status : sr_m;
    if (!stim.freeze) begin
      if (stim.flush) begin
        mv_m = 0; wb_m = 0; mr_m = 0; mw_m = 0; res_m = '0; sd_m = '0; dest_m = '0;
      end else begin
        mv_m = stim.valid;
        wb_m = stim.valid & stim.wb;
        mr_m = stim.valid & stim.mr;
        mw_m = stim.valid & stim.mw;
        res_m = stim.result; sd_m = stim.sd; dest_m = stim.dest;
      end
    end
    @(posedge clk);
    #1;
    sr_m = sr_n;
    check_state(tag);
  endtask

  task automatic idle_stim();
    stim.freeze = 0; stim.flush = 0; stim.valid = 0; stim.s = 0;
    stim.status = '0; stim.result = '0; stim.sd = '0; stim.dest = '0;
    stim.wb = 0; stim.mr = 0; stim.mw = 0; stim.cond = 4'hE;
  endtask

  initial begin
    idle_stim();
    model_reset();
    rst = 1'b1;
    #3;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load sr=1010 and a valid instruction, then reset mid-cycle.
    stim.valid = 1; stim.s = 1; stim.status = 4'b1010; stim.wb = 1; stim.mw = 1;
    stim.result = 32'hDEAD_BEEF; stim.sd = 32'h1234_5678; stim.dest = 4'd9;
    step("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("async_reset");
    #2;
    rst = 1'b0;

    // ADDS producing zero; bypass instance sees Z this cycle.
    idle_stim();
    stim.valid = 1; stim.s = 1; stim.result = 32'h0; stim.status = 4'b0110;
    stim.wb = 1; stim.dest = 4'd3; stim.cond = 4'h0;
    check_cond("adds_eq");
    step("adds");

    // Non-S instruction leaves flags alone; NE fails with Z=1.
    stim.s = 0; stim.status = 4'b1111; stim.cond = 4'h1; stim.result = 32'h55;
    check_cond("nons_ne");
    step("nons");

    // Freeze dominates flush; then flush alone gives a bubble.
    idle_stim();
    stim.valid = 1; stim.s = 1; stim.status = 4'b0001; stim.wb = 1; stim.dest = 4'd7;
    stim.result = 32'hA5A5_0001;
    step("load_sr0001");
    stim.freeze = 1; stim.flush = 1; stim.status = 4'b1110; stim.dest = 4'd2;
    stim.result = 32'hFFFF_FFFF; stim.mr = 1;
    for (int i = 0; i < 3; i++) begin
      check_cond("frozen");
      step("frozen");
    end
    stim.freeze = 0;
    check_cond("flush");
    step("flush_bubble");

    // Invalid instruction: controls gated, flags untouched, data still captured.
    idle_stim();
    stim.valid = 0; stim.mw = 1; stim.wb = 1; stim.s = 1; stim.status = 4'b1111;
    stim.result = 32'h0BAD_F00D; stim.sd = 32'hCAFE_0000; stim.dest = 4'd12;
    step("invalid");

    // Full condition sweep: non-bypass sees registered f, bypass sees ~f being written.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        idle_stim();
        stim.valid = 1; stim.s = 1; stim.status = 4'(f);
        step("sweep_load");
        stim.cond = 4'(c); stim.status = ~4'(f);
        check_cond($sformatf("sweep c=%0h f=%0h", c, f));
      end
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stim.freeze = ($urandom_range(0, 9) < 2);
      stim.flush  = ($urandom_range(0, 9) < 2);
      stim.valid  = ($urandom_range(0, 9) < 8);
      stim.s      = 1'($urandom);
      stim.status = 4'($urandom);
      stim.result = $urandom;
      stim.sd     = $urandom;
      stim.dest   = 4'($urandom);
      stim.wb     = 1'($urandom);
      stim.mr     = 1'($urandom);
      stim.mw     = 1'($urandom);
      stim.cond   = 4'($urandom);
      check_cond("rand");
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Stage directly downstream of the ALU.
- Latches the ALU result and status into the EX/MEM pipeline register.
- Owns the architectural NZCV status register, which drives the ALU SR input.
- Evaluates the 4-bit ARM condition field of the instruction in ID against the flags; the result feeds decode/hazard logic.

Parameters:
DATA_W, 32, datapath width of result and store data
COND_BYPASS, 1, 1 = condition check sees flags being written this cycle; 0 = sees registered flags only

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
freeze  in  1  hazard stall; hold all state
flush  in  1  kill the instruction currently in EX
ex_valid  in  1  EX holds a real instruction
ex_s  in  1  S bit; instruction updates flags
ex_status  in  4  ALU status {N,Z,C,V}
ex_result  in  DATA_W  ALU result
ex_store_data  in  DATA_W  Rm value for STR
ex_dest  in  4  destination register
ex_wb_en  in  1  writeback enable
ex_mem_r  in  1  load
ex_mem_w  in  1  store
id_cond  in  4  condition field of instruction in ID
sr  out  4  registered {N,Z,C,V}; to ALU SR
id_cond_ok  out  1  ID instruction passes its condition
mem_valid  out  1  EX/MEM register valid
mem_result  out  DATA_W  latched ALU result / address
mem_store_data  out  DATA_W  latched store data
mem_dest  out  4  latched destination
mem_wb_en  out  1  latched writeback enable (0 when invalid)
mem_mem_r  out  1  latched load (0 when invalid)
mem_mem_w  out  1  latched store (0 when invalid)

Behaviour:
- Reset (async, any time, including mid-stall): sr=0, mem_valid=0, all mem_* data=0, all mem_* controls=0. Takes effect immediately without a clock.
- Latency: one cycle EX→MEM. mem_* reflects the EX inputs captured at the previous rising edge.
- Capture conditions:
  - Priority per edge: rst > freeze > flush > normal.
  - freeze=1: pipeline register and sr hold, even if flush=1.
  - flush=1 and freeze=0: bubble. mem_valid=0; mem_wb_en, mem_mem_r, mem_mem_w = 0; data fields = 0; sr unchanged.
  - Normal: mem_valid=ex_valid. Controls are ANDed with ex_valid. Data is captured unconditionally.
- Status update: sr <= ex_status only when ex_valid & ex_s & !freeze & !flush. Otherwise sr holds.
  - CMP/TST arrive with ex_s=1 and ex_wb_en=0; the flags still update.
- Flag source for the condition check: sr_next = update ? ex_status : sr.
  - COND_BYPASS=1: condition evaluated on sr_next.
  - COND_BYPASS=0: condition evaluated on sr.
  - id_cond_ok is combinational.
- Condition codes (ARM encoding):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F 0 (reserved, never executes)
- No internal state other than sr and the pipeline register. Control outputs never take X after reset.

Decomposition:
- Shared package: condition-code constants COND_EQ..COND_NV; flag bit positions FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0; DATA_W default.
- One sub-module: cond_check (4-bit cond, 4-bit flags → pass), purely combinational. It is reused by the branch unit.

Test Plan:
- Reset: assert rst mid-cycle with mem_valid=1, sr=4'b1010 → sr=0, mem_valid=0, all mem_* =0 immediately, before the next edge.
- ADDS: ex_valid=1, ex_s=1, ex_result=32'h0, ex_status=4'b0110, ex_wb_en=1, ex_dest=4'd3 → next edge mem_result=0, mem_dest=3, mem_wb_en=1, sr=4'b0110. Same cycle with COND_BYPASS=1, id_cond=EQ → id_cond_ok=1.
- Non-S instruction: ex_s=0, ex_status=4'b1111 → sr unchanged. id_cond=NE with sr Z=1 → id_cond_ok=0.
- Freeze vs flush: sr=4'b0001, freeze=1 and flush=1 with new valid S instruction → mem_* and sr hold for every frozen cycle. Release freeze with flush=1 → bubble (mem_valid=0, mem_wb_en=0), sr still 4'b0001.
- Condition sweep: for each of 16 codes × all 16 NZCV values, compare id_cond_ok with a reference model (e.g. GE fails at 4'b1000, passes at 4'b1001). Run in both COND_BYPASS settings.
- Invalid gating: ex_valid=0, ex_mem_w=1, ex_wb_en=1, ex_s=1 → mem_mem_w=0, mem_wb_en=0, mem_valid=0, sr unchanged.
